traffic_phase_ctrl: RTL and testbench



---
 rtl/traffic_pkg.sv | 26 ++
 rtl/traffic_tick_gen.sv | 35 +++
 rtl/traffic_phase_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared colour codes and the phase state encoding for the intersection controller.
package traffic_pkg;

  // Car lamp codes, one-hot {RED,YELLOW,LEFT,GREEN}
  localparam logic [3:0] C_RED    = 4'b1000;
  localparam logic [3:0] C_YELLOW = 4'b0100;
  localparam logic [3:0] C_LEFT   = 4'b0010;
  localparam logic [3:0] C_GREEN  = 4'b0001;
  localparam logic [3:0] C_NONE   = 4'b0000;

  // Walker lamp codes {RED,GREEN}
  localparam logic [1:0] W_RED    = 2'b10;
  localparam logic [1:0] W_GREEN  = 2'b01;
  localparam logic [1:0] W_NONE   = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YEL1   = 3'd2,
    S_LEFT   = 3'd3,
    S_YEL2   = 3'd4,
    S_ALLRED = 3'd5,
    S_NIGHT  = 3'd6
  } state_t;

endpackage

// File: rtl/traffic_tick_gen.sv
// Prescaler: divides clk by TICK_DIV and strobes tick for one cycle per period.
// Counting only advances while en is high, so a pause freezes the time base.
module traffic_tick_gen #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  // Free-running divider that clears on request and holds while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

  // Strobe on the last count of each period, only while enabled
  always_comb begin
    tick = en && (cnt == LAST);
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase controller: round-robins NUM_DIR approach groups through
// GREEN, YELLOW, LEFT, YELLOW, ALL-RED, serves latched pedestrian requests,
// and supports a flashing-yellow night mode and pause on i_start low.
// All lamp outputs are decoded from registered state; the only combinational
// input path to the outputs is the i_start pause gate.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR  = 2,
  parameter int TICK_DIV = 100,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 2,
  parameter int T_LEFT   = 10,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 14,
  parameter int T_BLINK  = 6,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_start,
  input  logic                       i_night,
  input  logic [NUM_DIR-1:0]         i_ped_req,
  output logic [4*NUM_DIR-1:0]       o_car_traffic,
  output logic [2*NUM_DIR-1:0]       o_walker_traffic,
  output logic [$clog2(NUM_DIR)-1:0] o_active_dir,
  output logic                       o_tick
);

  localparam int DW = $clog2(NUM_DIR);
  localparam logic [CNT_W-1:0] WALK_END  = CNT_W'(T_WALK);
  localparam logic [CNT_W-1:0] BLINK_END = CNT_W'(T_WALK + T_BLINK);

  state_t             state;
  logic [DW-1:0]      dir;
  logic [CNT_W-1:0]   cnt;
  logic               blink;
  logic [NUM_DIR-1:0] ped_pend;
  logic [NUM_DIR-1:0] walk_grant;

  logic               tick;
  logic               tick_en;
  logic               tick_clr;
  logic [CNT_W-1:0]   ph_len;
  logic               ph_last;
  logic [DW-1:0]      dir_next;
  logic               enter_green;
  logic [DW-1:0]      green_dir;
  logic [NUM_DIR-1:0] grant_mask;

  // Time base runs only while started and out of IDLE; IDLE holds it at zero
  always_comb begin
    tick_en  = i_start && (state != S_IDLE);
    tick_clr = (state == S_IDLE);
  end

  traffic_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tick_en),
    .clr     (tick_clr),
    .tick    (tick)
  );

  // Length of the current phase in ticks and whether this tick ends it
  always_comb begin
    ph_len = CNT_W'(1);
    case (state)
      S_GREEN:        ph_len = CNT_W'(T_GREEN);
      S_YEL1, S_YEL2: ph_len = CNT_W'(T_YELLOW);
      S_LEFT:         ph_len = CNT_W'(T_LEFT);
      S_ALLRED:       ph_len = CNT_W'(T_ALLRED);
      default:        ph_len = CNT_W'(1);
    endcase
    ph_last  = (cnt == ph_len - CNT_W'(1));
    dir_next = (dir == DW'(NUM_DIR - 1)) ? '0 : dir + 1'b1;
  end

  // Detect GREEN entry and which pending crossings it grants (never the active road)
  always_comb begin
    enter_green = 1'b0;
    green_dir   = '0;
    if (state == S_IDLE && i_start) begin
      enter_green = 1'b1;
    end else if (state == S_ALLRED && tick && ph_last && !i_night) begin
      enter_green = 1'b1;
      green_dir   = dir_next;
    end
    grant_mask = '0;
    if (enter_green) grant_mask = ped_pend & ~(NUM_DIR'(1) << green_dir);
  end

  // Phase sequencer: advances on the tick that completes each phase.
  // Leaving NIGHT parks dir on the last road so the ALL-RED wrap lands on dir 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      dir   <= '0;
      cnt   <= '0;
      blink <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state <= S_GREEN;
            dir   <= '0;
            cnt   <= '0;
          end
        end
        S_NIGHT: begin
          if (tick) begin
            if (!i_night) begin
              state <= S_ALLRED;
              cnt   <= '0;
              blink <= 1'b0;
              dir   <= DW'(NUM_DIR - 1);
            end else begin
              blink <= ~blink;
            end
          end
        end
        default: begin
          if (tick) begin
            if (ph_last) begin
              cnt <= '0;
              case (state)
                S_GREEN: state <= S_YEL1;
                S_YEL1:  state <= (T_LEFT == 0) ? S_ALLRED : S_LEFT;
                S_LEFT:  state <= S_YEL2;
                S_YEL2:  state <= S_ALLRED;
                default: begin
                  if (i_night) begin
                    state <= S_NIGHT;
                    blink <= 1'b1;
                  end else begin
                    state <= S_GREEN;
                    dir   <= dir_next;
                  end
                end
              endcase
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Pedestrian latch: a new press wins over the clear made by a grant on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pend   <= '0;
      walk_grant <= '0;
    end else begin
      ped_pend <= (ped_pend & ~grant_mask) | i_ped_req;
      if (enter_green) begin
        walk_grant <= grant_mask;
      end else if (state == S_GREEN && tick && ph_last) begin
        walk_grant <= '0;
      end
    end
  end

  function automatic logic [3:0] car_colour(state_t s, logic active, logic blk);
    case (s)
      S_GREEN:        return active ? C_GREEN  : C_RED;
      S_YEL1, S_YEL2: return active ? C_YELLOW : C_RED;
      S_LEFT:         return active ? C_LEFT   : C_RED;
      S_ALLRED:       return C_RED;
      S_NIGHT:        return blk ? C_YELLOW : C_NONE;
      default:        return C_NONE;
    endcase
  endfunction

  // Walk window, then blink window (lit on even ticks counted from blink start), then red
  function automatic logic [1:0] walk_colour(state_t s, logic granted, logic [CNT_W-1:0] c);
    case (s)
      S_IDLE, S_NIGHT: return W_NONE;
      S_GREEN: begin
        if (!granted)           return W_RED;
        else if (c < WALK_END)  return W_GREEN;
        else if (c < BLINK_END) return (c[0] ^ WALK_END[0]) ? W_NONE : W_GREEN;
        else                    return W_RED;
      end
      default:         return W_RED;
    endcase
  endfunction

  // Lamp decode from registered state, blanked while paused
  always_comb begin
    o_car_traffic    = '0;
    o_walker_traffic = '0;
    o_active_dir     = '0;
    o_tick           = tick;
    if (i_start) begin
      o_active_dir = dir;
      for (int d = 0; d < NUM_DIR; d++) begin
        o_car_traffic[4*d +: 4]    = car_colour(state, dir == DW'(d), blink);
        o_walker_traffic[2*d +: 2] = walk_colour(state, walk_grant[d], cnt);
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: one instance with a LEFT phase and one
// built with T_LEFT=0, sharing clock and inputs.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_start = 1'b1;
  logic       i_night = 1'b0;
  logic [1:0] i_ped_req = 2'b00;

  logic [7:0] car_a, car_b;
  logic [3:0] walk_a, walk_b;
  logic [0:0] dir_a, dir_b;
  logic       tick_a, tick_b;

  int checks = 0;
  int errors = 0;

  // Clock
  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .NUM_DIR(2), .TICK_DIV(1), .T_GREEN(6), .T_YELLOW(1), .T_LEFT(2),
    .T_ALLRED(1), .T_WALK(3), .T_BLINK(2), .CNT_W(8)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_night(i_night),
    .i_ped_req(i_ped_req), .o_car_traffic(car_a), .o_walker_traffic(walk_a),
    .o_active_dir(dir_a), .o_tick(tick_a)
  );

  traffic_phase_ctrl #(
    .NUM_DIR(2), .TICK_DIV(1), .T_GREEN(6), .T_YELLOW(1), .T_LEFT(0),
    .T_ALLRED(1), .T_WALK(3), .T_BLINK(2), .CNT_W(8)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_night(i_night),
    .i_ped_req(i_ped_req), .o_car_traffic(car_b), .o_walker_traffic(walk_b),
    .o_active_dir(dir_b), .o_tick(tick_b)
  );

  // Expected car lamps at position pos of the cycle: G x6, Y, [L x2, Y,] R per road
  function automatic logic [7:0] exp_car(int pos, bit has_left);
    int per = has_left ? 11 : 8;
    int p = pos % (2 * per);
    int q = p % per;
    logic [3:0] col;
    if (q < 6)                    col = 4'b0001;
    else if (q == 6)              col = 4'b0100;
    else if (has_left && q < 9)   col = 4'b0010;
    else if (has_left && q == 9)  col = 4'b0100;
    else                          col = 4'b1000;
    return (p / per == 0) ? {4'b1000, col} : {col, 4'b1000};
  endfunction

  function automatic logic [0:0] exp_dir(int pos, bit has_left);
    int per = has_left ? 11 : 8;
    return 1'((pos % (2 * per)) / per);
  endfunction

  // Hold reset two cycles, release on a falling edge with i_start high
  task automatic begin_run;
    reset_n   = 1'b0;
    i_start   = 1'b0;
    i_night   = 1'b0;
    i_ped_req = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    i_start = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (car_a !== 8'h00)  begin errors++; $display("FAIL reset_car_a got %b exp %b", car_a, 8'h00); end
    checks++; if (walk_a !== 4'h0)  begin errors++; $display("FAIL reset_walk_a got %b exp %b", walk_a, 4'h0); end
    checks++; if (dir_a !== 1'b0)   begin errors++; $display("FAIL reset_dir_a got %b exp 0", dir_a); end
    checks++; if (tick_a !== 1'b0)  begin errors++; $display("FAIL reset_tick_a got %b exp 0", tick_a); end
    checks++; if (car_b !== 8'h00)  begin errors++; $display("FAIL reset_car_b got %b exp %b", car_b, 8'h00); end
  endtask

  task automatic test_sequence;
    begin_run();
    for (int s = 0; s < 44; s++) begin
      @(negedge clk);
      checks++; if (car_a !== exp_car(s, 1'b1)) begin errors++; $display("FAIL seq_car s=%0d got %b exp %b", s, car_a, exp_car(s, 1'b1)); end
      checks++; if (dir_a !== exp_dir(s, 1'b1)) begin errors++; $display("FAIL seq_dir s=%0d got %b exp %b", s, dir_a, exp_dir(s, 1'b1)); end
      checks++; if (walk_a !== 4'b1010) begin errors++; $display("FAIL seq_walk s=%0d got %b exp 1010", s, walk_a); end
      checks++; if (tick_a !== 1'b1) begin errors++; $display("FAIL seq_tick s=%0d got %b exp 1", s, tick_a); end
    end
  endtask

  task automatic test_ped;
    logic [1:0] blink_seq [6];
    logic [3:0] exp_w;
    blink_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
    begin_run();
    for (int s = 0; s < 56; s++) begin
      @(negedge clk);
      exp_w = 4'b1010;
      if (s >= 22 && s < 28) exp_w[3:2] = blink_seq[s - 22];
      checks++; if (walk_a !== exp_w) begin errors++; $display("FAIL ped_walk s=%0d got %b exp %b", s, walk_a, exp_w); end
      checks++; if (car_a !== exp_car(s, 1'b1)) begin errors++; $display("FAIL ped_car s=%0d got %b exp %b", s, car_a, exp_car(s, 1'b1)); end
      i_ped_req = (s == 12) ? 2'b10 : 2'b00;
    end
  endtask

  task automatic test_pause;
    int pos;
    begin_run();
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      if (s >= 8 && s <= 12) begin
        checks++; if (car_a !== 8'h00) begin errors++; $display("FAIL pause_car s=%0d got %b exp 0", s, car_a); end
        checks++; if (walk_a !== 4'h0) begin errors++; $display("FAIL pause_walk s=%0d got %b exp 0", s, walk_a); end
        checks++; if (tick_a !== 1'b0) begin errors++; $display("FAIL pause_tick s=%0d got %b exp 0", s, tick_a); end
        checks++; if (dir_a !== 1'b0)  begin errors++; $display("FAIL pause_dir s=%0d got %b exp 0", s, dir_a); end
      end else begin
        pos = (s < 8) ? s : s - 5;
        checks++; if (car_a !== exp_car(pos, 1'b1)) begin errors++; $display("FAIL pause_seq s=%0d got %b exp %b", s, car_a, exp_car(pos, 1'b1)); end
        checks++; if (dir_a !== exp_dir(pos, 1'b1)) begin errors++; $display("FAIL pause_seqdir s=%0d got %b exp %b", s, dir_a, exp_dir(pos, 1'b1)); end
      end
      if (s == 7)  i_start = 1'b0;
      if (s == 12) i_start = 1'b1;
    end
  endtask

  task automatic test_night;
    logic [7:0] exp_c;
    logic [3:0] exp_w;
    begin_run();
    for (int s = 0; s < 30; s++) begin
      @(negedge clk);
      if (s <= 10) begin
        exp_c = exp_car(s, 1'b1);
        exp_w = 4'b1010;
      end else if (s <= 16) begin
        exp_c = ((s - 11) % 2 == 0) ? 8'h44 : 8'h00;
        exp_w = 4'b0000;
      end else if (s == 17) begin
        exp_c = 8'h88;
        exp_w = 4'b1010;
      end else begin
        exp_c = exp_car(s - 18, 1'b1);
        exp_w = 4'b1010;
        checks++; if (dir_a !== exp_dir(s - 18, 1'b1)) begin errors++; $display("FAIL night_dir s=%0d got %b exp %b", s, dir_a, exp_dir(s - 18, 1'b1)); end
      end
      checks++; if (car_a !== exp_c) begin errors++; $display("FAIL night_car s=%0d got %b exp %b", s, car_a, exp_c); end
      checks++; if (walk_a !== exp_w) begin errors++; $display("FAIL night_walk s=%0d got %b exp %b", s, walk_a, exp_w); end
      checks++; if (tick_a !== 1'b1) begin errors++; $display("FAIL night_tick s=%0d got %b exp 1", s, tick_a); end
      if (s == 2)  i_night = 1'b1;
      if (s == 16) i_night = 1'b0;
    end
  endtask

  task automatic test_no_left;
    begin_run();
    for (int s = 0; s < 34; s++) begin
      @(negedge clk);
      checks++; if (car_b !== exp_car(s, 1'b0)) begin errors++; $display("FAIL noleft_car s=%0d got %b exp %b", s, car_b, exp_car(s, 1'b0)); end
      checks++; if (dir_b !== exp_dir(s, 1'b0)) begin errors++; $display("FAIL noleft_dir s=%0d got %b exp %b", s, dir_b, exp_dir(s, 1'b0)); end
    end
  endtask

  task automatic test_async_reset;
    begin_run();
    repeat (7) @(negedge clk);
    checks++; if (car_a !== 8'b1000_0100) begin errors++; $display("FAIL areset_pre got %b exp 10000100", car_a); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (car_a !== 8'h00)  begin errors++; $display("FAIL areset_car got %b exp 0", car_a); end
    checks++; if (walk_a !== 4'h0)  begin errors++; $display("FAIL areset_walk got %b exp 0", walk_a); end
    checks++; if (tick_a !== 1'b0)  begin errors++; $display("FAIL areset_tick got %b exp 0", tick_a); end
    checks++; if (dir_a !== 1'b0)   begin errors++; $display("FAIL areset_dir got %b exp 0", dir_a); end
    checks++; if (car_b !== 8'h00)  begin errors++; $display("FAIL areset_car_b got %b exp 0", car_b); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      checks++; if (car_a !== exp_car(s, 1'b1)) begin errors++; $display("FAIL areset_seq s=%0d got %b exp %b", s, car_a, exp_car(s, 1'b1)); end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ped();
    test_pause();
    test_night();
    test_no_left();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
